// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame FSM encoding,
// prefix byte constants and the FIFO entry width.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0]  PS2_EXT = 8'hE0;
  localparam logic [7:0]  PS2_BRK = 8'hF0;
  localparam int unsigned KEY_W   = 10;

  // Odd parity: data bits and parity bit together hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_key_fifo.sv
// Show-ahead FIFO for decoded keys; pointers carry an extra MSB so that
// full and empty can be told apart.
module ps2_key_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (wptr_q == rptr_q);
    full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push while full still lands.
    do_push = push & (~full | do_pop);
    drop    = push & full & ~do_pop;
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
    rdata   = empty ? '0 : mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronise and de-glitch the PS/2 lines, frame
// 11-bit packets, decode E0/F0 prefixes and queue keys in a FIFO.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  input  logic       rd_en,
  input  logic       ovf_clr,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_break,
  output logic       key_ext,
  output logic       fifo_full,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);

  localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_s, data_s;
  logic                   filt_q, filt_d, filt_prev_q;
  logic [FCW-1:0]         fcnt_q, fcnt_d;
  logic                   fall;

  ps2_state_e             state_q, state_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [TCW-1:0]         tocnt_q, tocnt_d;
  logic                   byte_vld_q, byte_vld_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;

  logic                   ext_q, ext_d;
  logic                   brk_q, brk_d;
  logic                   ovf_q, ovf_d;
  logic                   push;
  logic [KEY_W-1:0]       push_data;
  logic [KEY_W-1:0]       head;
  logic                   fifo_empty;
  logic                   fifo_drop;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = filt_prev_q & ~filt_q;

  // Filtered clock follows the synchronised line only after a run of
  // FILTER_LEN samples that all disagree with the current filtered level.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s != filt_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) filt_d = clk_s;
      else                                fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tocnt_d    = '0;
    byte_vld_d = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    if (state_q != ST_IDLE && !fall) begin
      if (tocnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
        state_d = ST_IDLE;
        ferr_d  = 1'b1;
      end else begin
        tocnt_d = tocnt_q + 1'b1;
      end
    end
    if (fall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!data_s) begin
            state_d  = ST_DATA;
            bitcnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d  = {data_s, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = data_s;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!odd_parity_ok(shift_q, par_q)) perr_d     = 1'b1;
          else if (!data_s)                   ferr_d     = 1'b1;
          else                                byte_vld_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // shift_q is still stable the cycle after STOP; the next fall is many cycles away.
  always_comb begin
    ext_d     = ext_q;
    brk_d     = brk_q;
    push      = 1'b0;
    push_data = {ext_q, brk_q, shift_q};
    if (perr_q || ferr_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_vld_q) begin
      if (shift_q == PS2_EXT)      ext_d = 1'b1;
      else if (shift_q == PS2_BRK) brk_d = 1'b1;
      else begin
        push  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
    if (fifo_drop)    ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
      state_q     <= ST_IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tocnt_q     <= '0;
      byte_vld_q  <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], PS2_CLK};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], PS2_DATA};
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      fcnt_q      <= fcnt_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tocnt_q     <= tocnt_d;
      byte_vld_q  <= byte_vld_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      ovf_q       <= ovf_d;
    end
  end

  ps2_key_fifo #(
    .WIDTH (KEY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata (push_data),
    .pop   (rd_en),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .drop  (fifo_drop)
  );

  assign key_valid  = ~fifo_empty;
  assign key_ext    = head[9];
  assign key_break  = head[8];
  assign key_code   = head[7:0];
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: PS/2 frames are bit-banged, expected
// keys go into a scoreboard queue and are compared as the FIFO is drained.
module tb_ps2_keyboard_rx;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 1500;
  localparam int unsigned HALF    = 25;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DATA = 1'b1;
  logic       rd_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_break;
  logic       key_ext;
  logic       fifo_full;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  int         checks = 0;
  int         failures = 0;
  int         pe_cnt = 0;
  int         fe_cnt = 0;
  int         pe0;
  int         fe0;
  logic [9:0] sb[$];

  ps2_keyboard_rx #(
    .FIFO_DEPTH     (DEPTH),
    .SYNC_STAGES    (2),
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .PS2_CLK    (PS2_CLK),
    .PS2_DATA   (PS2_DATA),
    .rd_en      (rd_en),
    .ovf_clr    (ovf_clr),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_break  (key_break),
    .key_ext    (key_ext),
    .fifo_full  (fifo_full),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (parity_err === 1'b1) pe_cnt++;
    if (frame_err === 1'b1)  fe_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, observed=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    PS2_DATA = b;
    repeat (HALF) @(negedge clk);
    PS2_CLK = 1'b0;
    repeat (HALF) @(negedge clk);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(stop);
    PS2_DATA = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, ~^b, 1'b1);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    repeat (4) @(negedge clk);
    while (key_valid === 1'b1 && guard < 16) begin
      chk({tag, "_sb_has_entry"}, 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) chk({tag, "_key"}, {22'd0, key_ext, key_break, key_code}, {22'd0, sb.pop_front()});
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      guard++;
    end
    chk({tag, "_sb_left"}, sb.size(), 0);
    chk({tag, "_valid_after_drain"}, key_valid, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_code", key_code, 0);
    chk("rst_fifo_full", fifo_full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_parity_err", parity_err, 0);
    chk("rst_frame_err", frame_err, 0);
    rstn = 1'b1;
    repeat (10) @(negedge clk);

    // plain make code, parity 0
    sb.push_back({2'b00, 8'h1C});
    send_frame(8'h1C, 1'b0, 1'b1);
    drain("make_1c");

    // break and extended-break sequences
    sb.push_back({2'b01, 8'h1C});
    send_good(8'hF0); send_good(8'h1C);
    sb.push_back({2'b11, 8'h75});
    send_good(8'hE0); send_good(8'hF0); send_good(8'h75);
    drain("prefix");

    // bad parity discards, next good frame received
    pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'h1D, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    chk("par_pulse", pe_cnt - pe0, 1);
    chk("par_no_frame_err", fe_cnt - fe0, 0);
    chk("par_fifo_empty", key_valid, 0);
    sb.push_back({2'b00, 8'h1B});
    send_good(8'h1B);
    drain("after_par");

    // bad stop bit
    pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'h22, ~^8'h22, 1'b0);
    repeat (5) @(negedge clk);
    chk("stop_frame_err", fe_cnt - fe0, 1);
    chk("stop_no_par_err", pe_cnt - pe0, 0);
    chk("stop_fifo_empty", key_valid, 0);

    // both bad: only parity_err
    pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'h1D, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("both_par_err", pe_cnt - pe0, 1);
    chk("both_no_frame_err", fe_cnt - fe0, 0);

    // an error clears a pending E0 prefix
    send_good(8'hE0);
    send_frame(8'h1D, 1'b0, 1'b1);
    sb.push_back({2'b00, 8'h1C});
    send_good(8'h1C);
    drain("err_clears_ext");

    // timeout after four data bits
    pe0 = pe_cnt; fe0 = fe_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0]);
    PS2_DATA = 1'b1;
    repeat (TIMEOUT + 200) @(negedge clk);
    chk("timeout_frame_err", fe_cnt - fe0, 1);
    chk("timeout_no_key", key_valid, 0);
    sb.push_back({2'b00, 8'h1B});
    send_good(8'h1B);
    drain("after_timeout");

    // overflow with depth 4
    sb.push_back({2'b00, 8'h15}); sb.push_back({2'b00, 8'h1D});
    sb.push_back({2'b00, 8'h24}); sb.push_back({2'b00, 8'h2D});
    send_good(8'h15); send_good(8'h1D); send_good(8'h24); send_good(8'h2D);
    repeat (4) @(negedge clk);
    chk("full_at_depth", fifo_full, 1);
    chk("no_ovf_at_depth", overflow, 0);
    send_good(8'h2C);
    repeat (4) @(negedge clk);
    chk("full_after_drop", fifo_full, 1);
    chk("ovf_set", overflow, 1);
    drain("overflow");
    chk("not_full_after_drain", fifo_full, 0);
    chk("ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // pop while empty is ignored
    rd_en = 1'b1;
    repeat (3) @(negedge clk);
    rd_en = 1'b0;
    chk("empty_pop_valid", key_valid, 0);
    sb.push_back({2'b00, 8'h2C});
    send_good(8'h2C);
    drain("after_empty_pop");

    // reset in the middle of a frame with a key queued
    send_good(8'h1C);
    repeat (4) @(negedge clk);
    chk("pre_reset_valid", key_valid, 1);
    ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", key_valid, 0);
    chk("mid_rst_code", key_code, 0);
    chk("mid_rst_full", fifo_full, 0);
    chk("mid_rst_ovf", overflow, 0);
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    PS2_DATA = 1'b1;
    repeat (20) @(negedge clk);
    sb.push_back({2'b00, 8'h1C});
    send_frame(8'h1C, 1'b0, 1'b1);
    drain("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
